beep_seq: RTL and testbench
===========================

BEEP_SEQ -- requirements
Module: beep_seq

Interface
REQ-001 SHALL have parameter TONE_HALF, default 25000: clock cycles per half-period of the tone square wave (>=1).
REQ-002 SHALL have parameter BEEP_CMAX, default 10000000: clock cycles per beep-on interval (>=1).
REQ-003 SHALL have parameter GAP_CMAX, default 5000000: clock cycles per silent gap after each beep (>=1).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tr_a, input, 1 bit: one-cycle trigger requesting a single beep.
REQ-007 SHALL have port tr_b, input, 1 bit: one-cycle trigger requesting a double beep.
REQ-008 SHALL have port buzz, output, 1 bit: tone drive to the buzzer pin.
REQ-009 SHALL have port busy, output, 1 bit: high while in ON or GAP.
REQ-010 SHALL have port q_full, output, 1 bit: high when all 4 request slots are occupied.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag, set when any request is dropped.

Function
REQ-012 SHALL hold requests in a 4-entry FIFO; each entry is 1 bit (0 = single, 1 = double).
REQ-013 SHALL enqueue on any cycle where tr_a or tr_b is high and a slot is free.
REQ-014 SHALL, when tr_a and tr_b are high in the same cycle, enqueue the single request first, then the double.
REQ-015 SHALL, in that simultaneous case, accept only the single request and drop the double when exactly one slot is free.
REQ-016 SHALL count a dequeue in the same cycle as a free slot: a full FIFO being dequeued accepts one new request.
REQ-017 SHALL drop a request that finds no slot and set ovf to 1; ovf stays 1 until reset.
REQ-018 SHALL implement FSM states IDLE, ON and GAP.
REQ-019 SHALL, in IDLE with FIFO non-empty, dequeue the head entry at the clock edge, load remaining-beep count (1 or 2) and enter ON.
REQ-020 SHALL give this latency: trigger sampled at edge N with FIFO empty and IDLE -> entry visible after N, dequeue at N+1, buzz=1 after N+1.
REQ-021 SHALL, on ON entry, set buzz=1 and clear the tone counter.
REQ-022 SHALL, in ON, invert buzz every TONE_HALF cycles.
REQ-023 SHALL remain in ON for exactly BEEP_CMAX cycles, then decrement the remaining-beep count and enter GAP.
REQ-024 SHALL hold buzz=0 for the whole of GAP.
REQ-025 SHALL remain in GAP for exactly GAP_CMAX cycles, then enter ON if beeps remain, else IDLE.
REQ-026 SHALL, on GAP->IDLE with FIFO non-empty, dequeue directly on the next cycle; there is no extra gap beyond GAP_CMAX.
REQ-027 SHALL not let triggers received during ON or GAP alter the current request; they are only queued.
REQ-028 SHALL size counters to clog2 of their parameter and wrap no counter other than by the explicit reload.
REQ-029 SHALL drive busy=1 exactly when state is ON or GAP.
REQ-030 SHALL drive q_full=1 exactly when the FIFO count is 4.

Reset
REQ-031 SHALL, with rst_n low, asynchronously force state IDLE, FIFO empty (count 0), all counters 0, buzz=0, busy=0, q_full=0, ovf=0.
REQ-032 SHALL discard any in-progress beep and all queued requests on reset asserted mid-operation; no beep resumes after release.
REQ-033 SHALL sample triggers from the first rising edge after rst_n deasserts.

Verification (TONE_HALF=2, BEEP_CMAX=8, GAP_CMAX=4)
REQ-034 SHALL cover: one tr_a pulse -> buzz pattern 1,1,0,0,1,1,0,0 starting 2 edges after the trigger, then 4 cycles of 0; busy high 12 cycles; ovf=0.
REQ-035 SHALL cover: one tr_b pulse -> two 8-cycle bursts separated by a 4-cycle gap; busy high 24 cycles.
REQ-036 SHALL cover: tr_a and tr_b high in the same cycle -> three bursts total (single then double); busy high 36 contiguous cycles.
REQ-037 SHALL cover: 6 tr_a pulses 2 cycles apart starting from IDLE -> first plays, 4 queued (q_full=1), 6th dropped, ovf=1; exactly 5 bursts; ovf still 1 afterwards.
REQ-038 SHALL cover: full FIFO plus a tr_a in the dequeue cycle -> request accepted, q_full stays 1, ovf unchanged.
REQ-039 SHALL cover: rst_n pulsed low in the 3rd cycle of ON with 2 queued -> buzz=0, busy=0, q_full=0, ovf=0 immediately; no bursts after release until a new trigger.

Source files
------------

// File: rtl/beep_seq.sv
// Buzzer sequencer: queues single/double beep requests in a 4-deep FIFO and
// plays each one as tone bursts separated by silent gaps.
module beep_seq #(
  parameter int TONE_HALF = 25000,
  parameter int BEEP_CMAX = 10000000,
  parameter int GAP_CMAX  = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tr_a,
  input  logic tr_b,
  output logic buzz,
  output logic busy,
  output logic q_full,
  output logic ovf
);

  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int BW = (BEEP_CMAX > 1) ? $clog2(BEEP_CMAX) : 1;
  localparam int GW = (GAP_CMAX  > 1) ? $clog2(GAP_CMAX)  : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CMAX - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CMAX - 1);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tone_cnt_reg, tone_cnt_next;
  logic [BW-1:0]   beep_cnt_reg, beep_cnt_next;
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [1:0]      rem_reg, rem_next;
  logic            buzz_reg, buzz_next;
  logic            ovf_reg, ovf_next;
  logic [2:0]      count_reg, count_next;
  logic [1:0]      rd_ptr_reg, rd_ptr_next;
  logic [1:0]      wr_ptr_reg, wr_ptr_next;
  logic            fifo_mem [4];

  logic            head;
  logic            deq;
  logic [2:0]      free_slots;
  logic [2:0]      free_after_a;
  logic            acc_a, acc_b, drop;

  assign head = fifo_mem[rd_ptr_reg];

  always_comb begin
    state_next    = state_reg;
    tone_cnt_next = tone_cnt_reg;
    beep_cnt_next = beep_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    rem_next      = rem_reg;
    buzz_next     = buzz_reg;
    deq           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (count_reg != 3'd0) begin
          deq           = 1'b1;
          state_next    = ON;
          rem_next      = head ? 2'd2 : 2'd1;
          tone_cnt_next = '0;
          beep_cnt_next = '0;
          buzz_next     = 1'b1;
        end
      end
      ON: begin
        if (beep_cnt_reg == BEEP_LAST) begin
          state_next    = GAP;
          beep_cnt_next = '0;
          gap_cnt_next  = '0;
          tone_cnt_next = '0;
          buzz_next     = 1'b0;
          rem_next      = rem_reg - 2'd1;
        end else begin
          beep_cnt_next = beep_cnt_reg + 1'b1;
          if (tone_cnt_reg == TONE_LAST) begin
            tone_cnt_next = '0;
            buzz_next     = ~buzz_reg;
          end else begin
            tone_cnt_next = tone_cnt_reg + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          // Chain straight into the next queued request so back-to-back
          // requests see only the normal gap between bursts.
          if (rem_reg != 2'd0) begin
            state_next    = ON;
            tone_cnt_next = '0;
            beep_cnt_next = '0;
            buzz_next     = 1'b1;
          end else if (count_reg != 3'd0) begin
            deq           = 1'b1;
            state_next    = ON;
            rem_next      = head ? 2'd2 : 2'd1;
            tone_cnt_next = '0;
            beep_cnt_next = '0;
            buzz_next     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A slot freed by this cycle's dequeue is available to this cycle's trigger.
  always_comb begin
    free_slots   = 3'd4 - count_reg + {2'b00, deq};
    acc_a        = tr_a && (free_slots != 3'd0);
    free_after_a = free_slots - {2'b00, acc_a};
    acc_b        = tr_b && (free_after_a != 3'd0);
    drop         = (tr_a && !acc_a) || (tr_b && !acc_b);
    wr_ptr_next  = wr_ptr_reg + {1'b0, acc_a} + {1'b0, acc_b};
    rd_ptr_next  = rd_ptr_reg + {1'b0, deq};
    count_next   = count_reg + {2'b00, acc_a} + {2'b00, acc_b} - {2'b00, deq};
    ovf_next     = ovf_reg | drop;
  end

  always_ff @(posedge clk) begin
    if (acc_a) fifo_mem[wr_ptr_reg] <= 1'b0;
    if (acc_b) fifo_mem[wr_ptr_reg + {1'b0, acc_a}] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tone_cnt_reg <= '0;
      beep_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      rem_reg      <= '0;
      buzz_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      tone_cnt_reg <= tone_cnt_next;
      beep_cnt_reg <= beep_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      rem_reg      <= rem_next;
      buzz_reg     <= buzz_next;
      ovf_reg      <= ovf_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  assign buzz   = buzz_reg;
  assign busy   = (state_reg == ON) || (state_reg == GAP);
  assign q_full = (count_reg == 3'd4);
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_beep_seq.sv
// Bench for beep_seq: a request-queue/playback-timeline model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_beep_seq;
  localparam int T = 2;
  localparam int B = 8;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tr_a, tr_b;
  logic buzz, busy, q_full, ovf;

  int tests = 0;
  int fails = 0;

  beep_seq #(.TONE_HALF(T), .BEEP_CMAX(B), .GAP_CMAX(G)) dut (
    .clk(clk), .rst_n(rst_n), .tr_a(tr_a), .tr_b(tr_b),
    .buzz(buzz), .busy(busy), .q_full(q_full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending requests and a position k inside the job being played.
  int  mq[$];
  bit  job = 0;
  int  k = 0;
  int  jl = 0;
  bit  movf = 0;

  function automatic int m_buzz();
    int ph;
    ph = k % (B + G);
    return (job && ph < B && ((ph / T) % 2 == 0)) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        job = 0; k = 0; jl = 0; movf = 0;
      end else begin
        bit finishing;
        finishing = job && (k == jl - 1);
        if ((!job || finishing) && mq.size() > 0) begin
          jl = (mq.pop_front() == 1) ? 2 * (B + G) : (B + G);
          k = 0;
          job = 1;
        end else if (finishing) begin
          job = 0;
        end else if (job) begin
          k++;
        end
        if (tr_a) begin
          if (mq.size() < 4) mq.push_back(0); else movf = 1;
        end
        if (tr_b) begin
          if (mq.size() < 4) mq.push_back(1); else movf = 1;
        end
      end
      #1;
      chk("buzz",   int'(buzz),   m_buzz());
      chk("busy",   int'(busy),   int'(job));
      chk("q_full", int'(q_full), (mq.size() == 4) ? 1 : 0);
      chk("ovf",    int'(ovf),    int'(movf));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; tr_a = 1'b0; tr_b = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_count(input int n, output int busy_cnt, output int buzz_cnt,
                           output int max_run);
    int run;
    busy_cnt = 0; buzz_cnt = 0; max_run = 0; run = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      buzz_cnt += int'(buzz);
      run = busy ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  endtask

  initial begin
    logic [13:0] exp_buzz;
    logic [13:0] exp_busy;
    int bc, zc, mr;

    rst_n = 1'b0; tr_a = 1'b0; tr_b = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_buzz", int'(buzz), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qfull", int'(q_full), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    // Single beep: tone pattern then silent gap.
    tr_a = 1'b1; @(negedge clk); tr_a = 1'b0;
    exp_buzz = 14'b00000000110011;
    exp_busy = 14'b00111111111111;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("single_buzz[%0d]", i), int'(buzz), int'(exp_buzz[i]));
      chk($sformatf("single_busy[%0d]", i), int'(busy), int'(exp_busy[i]));
    end
    chk("single_ovf", int'(ovf), 0);

    // Double beep.
    do_reset();
    tr_b = 1'b1; @(negedge clk); tr_b = 1'b0;
    run_count(40, bc, zc, mr);
    chk("double_busy_cycles", bc, 24);
    chk("double_buzz_high", zc, 8);

    // Simultaneous single and double.
    do_reset();
    tr_a = 1'b1; tr_b = 1'b1; @(negedge clk); tr_a = 1'b0; tr_b = 1'b0;
    run_count(50, bc, zc, mr);
    chk("both_busy_cycles", bc, 36);
    chk("both_busy_contig", mr, 36);
    chk("both_buzz_high", zc, 12);

    // Six singles two cycles apart: one plays, four queue, one dropped.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      tr_a = (c % 2 == 0);
      @(negedge clk);
    end
    tr_a = 1'b0;
    chk("burst6_qfull", int'(q_full), 1);
    chk("burst6_ovf", int'(ovf), 1);
    run_count(80, bc, zc, mr);
    chk("burst6_buzz_high", zc + 4, 20);
    chk("burst6_ovf_after", int'(ovf), 1);

    // Full FIFO plus a trigger in the dequeue cycle is accepted.
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      tr_a = (c == 0 || c == 2 || c == 4 || c == 6 || c == 8 || c == 13);
      @(negedge clk);
    end
    tr_a = 1'b0;
    chk("deqfull_qfull", int'(q_full), 1);
    chk("deqfull_ovf", int'(ovf), 0);

    // Reset in the 3rd ON cycle with two queued requests.
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      tr_a = (c == 0 || c == 1);
      tr_b = (c == 1);
      @(negedge clk);
    end
    tr_a = 1'b0; tr_b = 1'b0;
    chk("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_buzz", int'(buzz), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_qfull", int'(q_full), 0);
    chk("midrst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_count(60, bc, zc, mr);
    chk("midrst_no_busy", bc, 0);
    chk("midrst_no_buzz", zc, 0);

    // Randomized traffic with occasional resets, checked by the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0; tr_a = 1'b0; tr_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      tr_a = ($urandom_range(0, 5) == 0);
      tr_b = ($urandom_range(0, 8) == 0);
    end
    tr_a = 1'b0; tr_b = 1'b0;
    @(negedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
